hit_debounce: RTL and testbench

- Input conditioner placed directly upstream of the hit/score stage.
- Turns the raw, asynchronous, bouncy player hit signal into three things:
  - a clean debounced level;
  - exactly one single-cycle `hit` pulse per genuine press;
  - press and glitch counters for debug.
- The score stage consumes `hit` in place of the raw pin, so every press is counted once and only once.

---
 rtl/hit_debounce.sv | 108 ++++++++++
 tb/tb_hit_debounce.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hit_debounce.sv
// Debounces an asynchronous hit input. It emits one registered hit pulse per accepted press and keeps press and glitch counters.
// Optional post-release lockout is enabled by defining HIT_LOCKOUT_EN.
module hit_debounce #(
  parameter int STABLE_CYCLES  = 4,
  parameter int LOCKOUT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in1,
  output logic       hit,
  output logic       level,
  output logic [7:0] press_count,
  output logic [7:0] glitch_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || LOCKOUT_CYCLES < 1) begin : g_bad_param
    $error("hit_debounce: STABLE_CYCLES must be >= 2 and LOCKOUT_CYCLES >= 1");
  end

`ifdef HIT_LOCKOUT_EN
  typedef enum logic [2:0] {IDLE, RISE_CHK, HIGH, FALL_CHK, LOCKOUT} state_t;
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
  logic [LW-1:0] lcnt;
`else
  typedef enum logic [2:0] {IDLE, RISE_CHK, HIGH, FALL_CHK} state_t;
`endif

  state_t        state;
  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1        <= 1'b0;
      s            <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      hit          <= 1'b0;
      level        <= 1'b0;
      press_count  <= 8'd0;
      glitch_count <= 8'd0;
`ifdef HIT_LOCKOUT_EN
      lcnt         <= '0;
`endif
    end else begin
      sync1 <= in1;
      s     <= sync1;
      hit   <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= RISE_CHK;
            cnt   <= CW'(1);
          end
        end
        RISE_CHK: begin
          if (!s) begin
            state <= IDLE;
            if (glitch_count != 8'hFF) glitch_count <= glitch_count + 8'd1;
          end else if (cnt == CNT_LAST) begin
            state       <= HIGH;
            level       <= 1'b1;
            hit         <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HIGH: begin
          if (!s) begin
            state <= FALL_CHK;
            cnt   <= CW'(1);
          end
        end
        FALL_CHK: begin
          // A bounce back to high while checking the release is a glitch. It never produces a new press.
          if (s) begin
            state <= HIGH;
            if (glitch_count != 8'hFF) glitch_count <= glitch_count + 8'd1;
          end else if (cnt == CNT_LAST) begin
            level <= 1'b0;
`ifdef HIT_LOCKOUT_EN
            state <= LOCKOUT;
            lcnt  <= '0;
`else
            state <= IDLE;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef HIT_LOCKOUT_EN
        LOCKOUT: begin
          if (lcnt == LOCK_LAST) state <= IDLE;
          else                   lcnt  <= lcnt + LW'(1);
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_debounce.sv
// Directed bench for hit_debounce with STABLE_CYCLES=4 and LOCKOUT_CYCLES=8; it follows HIT_LOCKOUT_EN.
module tb_hit_debounce;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in1 = 1'b0;
  logic       hit;
  logic       level;
  logic [7:0] press_count;
  logic [7:0] glitch_count;

  int tests = 0;
  int fails = 0;
  int hit_cnt = 0;
  int fall_cnt = 0;
  int lvl_cnt = 0;
  logic prev_level = 1'b0;

  hit_debounce #(.STABLE_CYCLES(4), .LOCKOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .in1(in1), .hit(hit), .level(level),
    .press_count(press_count), .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic in1;
    logic hit;
    logic level;
  } vec_t;
  vec_t vecs[30];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (hit) hit_cnt++;
    if (level) lvl_cnt++;
    if (prev_level && !level) fall_cnt++;
    prev_level = level;
  endtask

  task automatic press(input int hi, input int lo);
    in1 = 1'b1;
    repeat (hi) tick();
    in1 = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_reset();
    in1 = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    hit_cnt = 0; fall_cnt = 0; lvl_cnt = 0;
    prev_level = level;
  endtask

  task automatic wait_hit(input int max, output int idx);
    idx = -1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (hit) begin
        idx = i;
        return;
      end
    end
  endtask

  task automatic wait_level_low(input int max, output int idx);
    idx = -1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (!level) begin
        idx = i;
        return;
      end
    end
  endtask

  initial begin
    int idx;
    int exp_relock;

    for (int k = 0; k < 30; k++) begin
      vecs[k].in1   = (k < 20);
      vecs[k].hit   = (k == 5);
      vecs[k].level = (k >= 5 && k < 25);
    end

    // Reset held while the input toggles.
    #2 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in1 = k[0];
      tick();
    end
    chk("reset_hit", hit, 0);
    chk("reset_level", level, 0);
    chk("reset_press", press_count, 0);
    chk("reset_glitch", glitch_count, 0);
    in1 = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Clean press: walk the per-edge table.
    for (int k = 0; k < 30; k++) begin
      in1 = vecs[k].in1;
      tick();
      chk($sformatf("clean_hit_e%0d", k), hit, vecs[k].hit);
      chk($sformatf("clean_level_e%0d", k), level, vecs[k].level);
    end
    repeat (15) tick();
    chk("clean_press", press_count, 1);
    chk("clean_glitch", glitch_count, 0);

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    chk("async_press", press_count, 0);
    chk("async_level", level, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a rise check with the input still high.
    in1 = 1'b1;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_level", level, 0);
    chk("midrst_hit", hit, 0);
    tick();
    reset = 1'b0;
    wait_hit(20, idx);
    chk("midrst_hit_edge", idx, 5);
    chk("midrst_press", press_count, 1);
    in1 = 1'b0;
    repeat (20) tick();

    // A three-sample pulse is rejected; a four-sample pulse is accepted.
    do_reset();
    press(3, 12);
    chk("glitch_nohit", hit_cnt, 0);
    chk("glitch_nolevel", lvl_cnt, 0);
    chk("glitch_count1", glitch_count, 1);
    press(4, 20);
    chk("short4_hit", hit_cnt, 1);
    chk("short4_press", press_count, 1);

    // Release bounce: low for 2, high for 1, then low for good.
    do_reset();
    in1 = 1'b1;
    repeat (10) tick();
    in1 = 1'b0; repeat (2) tick();
    in1 = 1'b1; tick();
    in1 = 1'b0; repeat (20) tick();
    chk("bounce_hits", hit_cnt, 1);
    chk("bounce_falls", fall_cnt, 1);
    chk("bounce_glitch", glitch_count, 1);
    chk("bounce_level", level, 0);

    // press_count wraps from 255 to 0.
    do_reset();
    repeat (255) press(6, 20);
    chk("wrap_255", press_count, 255);
    press(6, 20);
    chk("wrap_0", press_count, 0);
    chk("wrap_hits", hit_cnt, 256);
    chk("wrap_glitch", glitch_count, 0);

    // glitch_count saturates at 255.
    repeat (254) press(3, 10);
    chk("sat_254", glitch_count, 254);
    repeat (46) press(3, 10);
    chk("sat_255", glitch_count, 255);
    chk("sat_press", press_count, 0);

    // Re-press two edges after level falls.
    do_reset();
    in1 = 1'b1;
    repeat (10) tick();
    in1 = 1'b0;
    wait_level_low(20, idx);
    chk("relock_fall_edge", idx, 5);
    tick();
    in1 = 1'b1;
`ifdef HIT_LOCKOUT_EN
    exp_relock = 10;
`else
    exp_relock = 5;
`endif
    wait_hit(30, idx);
    chk("relock_hit_edge", idx, exp_relock);
    chk("relock_press", press_count, 2);
    in1 = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
